// File: rtl/ram_pkg.sv
// Shared types and read-mode constants for the parametrised clearable RAM.
package ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } ram_clr_state_t;

  localparam int RD_COMB = 0;
  localparam int RD_REG  = 1;

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks every word once, emitting a zero-write per cycle,
// and reports the sweep through busy and a one-cycle clr_done pulse.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int          ADDR_W       = 12,
  parameter int unsigned DEPTH        = 4096,
  parameter bit          CLR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              busy,
  output logic              clr_done,
  output logic              wr_en_clr,
  output logic [ADDR_W-1:0] wr_addr_clr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 32'd1);
  localparam ram_clr_state_t    RST_ST    = CLR_ON_RESET ? ST_CLEAR : ST_IDLE;

  ram_clr_state_t    state_r;
  logic [ADDR_W-1:0] cnt_r;
  logic              busy_r;
  logic              done_r;

  // Sweep FSM; busy mirrors the CLEAR state so the write strobe is a flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RST_ST;
      cnt_r   <= '0;
      busy_r  <= CLR_ON_RESET;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (clear) begin
            state_r <= ST_CLEAR;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // The last word's zero write lands on the same edge that returns to IDLE.
          if (cnt_r == LAST_ADDR) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + ADDR_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign clr_done    = done_r;
  assign wr_en_clr   = busy_r;
  assign wr_addr_clr = cnt_r;

endmodule

// File: rtl/ram_param_clr.sv
// Parametrised single-port RAM with hardware clear sweep and selectable
// combinational or registered (read-before-write) read path.
module ram_param_clr
  import ram_pkg::*;
#(
  parameter int          DATA_W       = 16,
  parameter int          ADDR_W       = 12,
  parameter int unsigned DEPTH        = 4096,
  parameter int          READ_REG     = 0,
  parameter bit          CLR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic              clear,
  output logic [DATA_W-1:0] out,
  output logic              busy,
  output logic              clr_done
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              wr_en_clr_s;
  logic [ADDR_W-1:0] wr_addr_clr_s;
  logic              in_range_s;
  logic              user_wr_s;
  logic [DATA_W-1:0] rd_data_s;

  ram_clr_seq #(
    .ADDR_W       (ADDR_W),
    .DEPTH        (DEPTH),
    .CLR_ON_RESET (CLR_ON_RESET)
  ) u_clr_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .busy        (busy),
    .clr_done    (clr_done),
    .wr_en_clr   (wr_en_clr_s),
    .wr_addr_clr (wr_addr_clr_s)
  );

  assign in_range_s = (32'(address) < DEPTH);
  // A clear request in the same cycle wins over the user write.
  assign user_wr_s  = load && !clear && !busy && in_range_s;

  // Storage: sweep zero-write has priority; contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (wr_en_clr_s) begin
      mem_r[wr_addr_clr_s] <= '0;
    end else if (user_wr_s) begin
      mem_r[address] <= in;
    end
  end

  // Raw array read, zero for addresses beyond DEPTH.
  always_comb begin
    rd_data_s = '0;
    if (in_range_s) begin
      rd_data_s = mem_r[address];
    end else begin
      rd_data_s = '0;
    end
  end

  if (READ_REG == RD_REG) begin : g_rd_reg
    logic [DATA_W-1:0] out_r;

    // Registered read samples the pre-write contents on the same edge as a write.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_r <= '0;
      end else if (busy) begin
        out_r <= '0;
      end else begin
        out_r <= rd_data_s;
      end
    end

    assign out = busy ? '0 : out_r;
  end else begin : g_rd_comb
    assign out = busy ? '0 : rd_data_s;
  end

endmodule

// File: tb/tb_ram_param_clr.sv
// Scoreboard bench for ram_param_clr: three instances (comb read, registered
// read, short depth) share clock and reset; expectations are queued per cycle.
module tb_ram_param_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] in_a, in_b, in_c;
  logic [3:0]  addr_a, addr_b, addr_c;
  logic        load_a, load_b, load_c;
  logic        clear_a, clear_b, clear_c;
  logic [15:0] out_a, out_b, out_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;

  ram_param_clr #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .READ_REG(0), .CLR_ON_RESET(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .address(addr_a), .load(load_a),
    .clear(clear_a), .out(out_a), .busy(busy_a), .clr_done(done_a));

  ram_param_clr #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .READ_REG(1), .CLR_ON_RESET(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .address(addr_b), .load(load_b),
    .clear(clear_b), .out(out_b), .busy(busy_b), .clr_done(done_b));

  ram_param_clr #(.DATA_W(16), .ADDR_W(4), .DEPTH(10), .READ_REG(0), .CLR_ON_RESET(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .in(in_c), .address(addr_c), .load(load_c),
    .clear(clear_c), .out(out_c), .busy(busy_c), .clr_done(done_c));

  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] ev;
    string       name;
  } exp_t;

  localparam int S_OUT_A = 0, S_BUSY_A = 1, S_DONE_A = 2;
  localparam int S_OUT_B = 3, S_BUSY_B = 4, S_DONE_B = 5;
  localparam int S_OUT_C = 6, S_BUSY_C = 7, S_DONE_C = 8;

  exp_t sb_q[$];
  int   cyc_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int sel, input logic [15:0] ev, input string name);
    exp_t e;
    e.cyc  = cyc_cnt;
    e.sel  = sel;
    e.ev   = ev;
    e.name = name;
    sb_q.push_back(e);
  endtask

  function automatic logic [15:0] pick(input int sel);
    case (sel)
      S_OUT_A:  return out_a;
      S_BUSY_A: return {15'd0, busy_a};
      S_DONE_A: return {15'd0, done_a};
      S_OUT_B:  return out_b;
      S_BUSY_B: return {15'd0, busy_b};
      S_DONE_B: return {15'd0, done_b};
      S_OUT_C:  return out_c;
      S_BUSY_C: return {15'd0, busy_c};
      S_DONE_C: return {15'd0, done_c};
      default:  return 16'hxxxx;
    endcase
  endfunction

  // Monitor: on each falling edge, compare every expectation due this cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
      e   = sb_q.pop_front();
      act = pick(e.sel);
      n_cmp++;
      if (e.cyc != cyc_cnt || act !== e.ev) begin
        n_err++;
        $display("FAIL %s cyc=%0d (due %0d): got %h, want %h", e.name, cyc_cnt, e.cyc, act, e.ev);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    {in_a, in_b, in_c}          = {16'h0000, 16'h0000, 16'h0000};
    {addr_a, addr_b, addr_c}    = {4'd0, 4'd0, 4'd0};
    {load_a, load_b, load_c}    = {1'b0, 1'b0, 1'b0};
    {clear_a, clear_b, clear_c} = {1'b0, 1'b0, 1'b0};
    tick();
    tick();
    chk(S_BUSY_A, 16'd1, "rst_busy_a");
    chk(S_DONE_A, 16'd0, "rst_done_a");
    chk(S_OUT_B,  16'd0, "rst_out_b");
    chk(S_BUSY_C, 16'd1, "rst_busy_c");
    chk(S_DONE_C, 16'd0, "rst_done_c");

    // Auto-clear after reset with load held high on A and B.
    rst_n  = 1'b1;
    load_a = 1'b1; in_a = 16'hFFFF;
    load_b = 1'b1; in_b = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      addr_a = 4'(i);
      addr_b = 4'(i);
      chk(S_BUSY_A, 16'd1, "auto_busy_a");
      chk(S_DONE_A, 16'd0, "auto_done_a");
      chk(S_OUT_A,  16'd0, "auto_out_a");
      chk(S_BUSY_B, 16'd1, "auto_busy_b");
      chk(S_BUSY_C, 16'(i < 10), "auto_busy_c");
      chk(S_DONE_C, 16'(i == 10), "auto_done_c");
      tick();
    end
    load_a = 1'b0;
    load_b = 1'b0;
    chk(S_BUSY_A, 16'd0, "auto_end_busy_a");
    chk(S_DONE_A, 16'd1, "auto_end_done_a");
    chk(S_BUSY_B, 16'd0, "auto_end_busy_b");
    chk(S_DONE_B, 16'd1, "auto_end_done_b");
    chk(S_DONE_C, 16'd0, "auto_end_done_c");
    for (int i = 0; i < 16; i++) begin
      addr_a = 4'(i);
      chk(S_OUT_A, 16'd0, "auto_zero_a");
      if (i > 0) chk(S_DONE_A, 16'd0, "auto_done_low_a");
      tick();
    end

    // Combinational read after write.
    addr_a = 4'd5; in_a = 16'hBEEF; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    chk(S_OUT_A, 16'hBEEF, "comb_rd_5");
    n_cmp++;
    if (out_a !== 16'hBEEF) begin
      n_err++;
      $display("FAIL comb_rd_5_direct: got %h, want BEEF", out_a);
    end
    tick();
    addr_a = 4'd6;
    chk(S_OUT_A, 16'h0000, "comb_rd_6");
    #1;
    n_cmp++;
    if (out_a !== 16'h0000) begin
      n_err++;
      $display("FAIL comb_rd_6_direct: got %h, want 0000", out_a);
    end
    tick();

    // Registered read-before-write.
    addr_b = 4'd3; in_b = 16'h1234; load_b = 1'b1;
    tick();
    load_b = 1'b0;
    chk(S_OUT_B, 16'h0000, "reg_rd_old");
    tick();
    chk(S_OUT_B, 16'h1234, "reg_rd_new");
    n_cmp++;
    if (out_b !== 16'h1234) begin
      n_err++;
      $display("FAIL reg_rd_new_direct: got %h, want 1234", out_b);
    end
    tick();

    // Requested clear colliding with a write, plus a mid-sweep clear pulse.
    addr_a = 4'd2; in_a = 16'hAAAA; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    chk(S_OUT_A, 16'hAAAA, "coll_pre");
    tick();
    in_a = 16'h5555; load_a = 1'b1; clear_a = 1'b1;
    chk(S_BUSY_A, 16'd0, "coll_busy_pre");
    chk(S_OUT_A, 16'hAAAA, "coll_out_pre");
    tick();
    for (int i = 0; i < 16; i++) begin
      clear_a = (i == 5);
      chk(S_BUSY_A, 16'd1, "coll_busy");
      chk(S_OUT_A,  16'd0, "coll_out_sweep");
      chk(S_DONE_A, 16'd0, "coll_done_low");
      tick();
    end
    load_a = 1'b0; clear_a = 1'b0;
    chk(S_BUSY_A, 16'd0, "coll_busy_end");
    chk(S_DONE_A, 16'd1, "coll_done");
    chk(S_OUT_A,  16'd0, "coll_addr2_zero");
    n_cmp++;
    if (busy_a !== 1'b0 || done_a !== 1'b1) begin
      n_err++;
      $display("FAIL coll_done_direct: busy=%b done=%b, want 0/1", busy_a, done_a);
    end
    tick();
    chk(S_DONE_A, 16'd0, "coll_done_pulse");
    chk(S_OUT_A,  16'd0, "coll_addr2_zero2");
    tick();

    // Reset in the middle of a sweep.
    addr_a = 4'd5; in_a = 16'h1111; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    chk(S_OUT_A, 16'h1111, "mid_pre");
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk(S_BUSY_A, 16'd1, "mid_busy_pre");
      chk(S_DONE_A, 16'd0, "mid_done_pre");
      tick();
    end
    rst_n = 1'b0;
    chk(S_BUSY_A, 16'd1, "mid_rst_busy_a");
    chk(S_DONE_A, 16'd0, "mid_rst_done_a");
    chk(S_BUSY_B, 16'd1, "mid_rst_busy_b");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk(S_BUSY_A, 16'd1, "mid_busy_a");
      chk(S_DONE_A, 16'd0, "mid_done_a");
      chk(S_BUSY_B, 16'd1, "mid_busy_b");
      chk(S_BUSY_C, 16'(i < 10), "mid_busy_c");
      chk(S_DONE_C, 16'(i == 10), "mid_done_c");
      tick();
    end
    chk(S_BUSY_A, 16'd0, "mid_busy_end");
    chk(S_DONE_A, 16'd1, "mid_done_end");
    chk(S_OUT_A,  16'd0, "mid_addr5_zero");
    tick();
    chk(S_DONE_A, 16'd0, "mid_done_once");
    tick();

    // Out-of-range access on the 10-deep instance.
    for (int i = 0; i < 10; i++) begin
      addr_c = 4'(i); in_c = 16'(16'hC000 + i); load_c = 1'b1;
      tick();
    end
    addr_c = 4'd12; in_c = 16'h7777; load_c = 1'b1;
    tick();
    load_c = 1'b0;
    chk(S_OUT_C, 16'h0000, "oor_rd_12");
    n_cmp++;
    if (out_c !== 16'h0000) begin
      n_err++;
      $display("FAIL oor_rd_12_direct: got %h, want 0000", out_c);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      addr_c = 4'(i);
      chk(S_OUT_C, 16'(16'hC000 + i), "oor_keep");
      tick();
    end

    tick();
    tick();
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_err++;
      $display("FAIL %s: expectation never checked, want %h", e.name, e.ev);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_param_clr.md
Name: ram_param_clr

Overview:
- Parametrised successor to the fixed 16-bit x 4K data RAM, for the Hack-style memory map.
- Adds configurable width and depth, and a selectable combinational or registered read.
- Adds a hardware clear sequencer. It zeroes memory after reset or on request, so no simulation-only initialisation is needed.
- Intended as the common building block for data RAM, screen buffer and scratch memories.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 12, address width in bits.
- DEPTH, 4096, number of words. Must satisfy 1 <= DEPTH <= 2**ADDR_W.
- READ_REG, 0, read mode. 0 = combinational read (out follows address). 1 = registered read, 1-cycle latency.
- CLR_ON_RESET, 1, mode after reset. 1 = clear sweep starts automatically when reset is released. 0 = IDLE after reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  DATA_W  write data.
- address  input  ADDR_W  read/write address.
- load  input  1  write enable. Writes in[] to address at the rising edge.
- clear  input  1  clear request, sampled at the rising edge.
- out  output  DATA_W  read data.
- busy  output  1  high while the clear sweep runs.
- clr_done  output  1  one-cycle pulse when a sweep completes.

Behaviour:
Reset state
- Asynchronous reset (rst_n=0) forces:
  - state = CLEAR if CLR_ON_RESET=1, otherwise IDLE
  - sweep counter = 0
  - busy = CLR_ON_RESET
  - clr_done = 0
  - registered out (READ_REG=1) = 0
- Memory contents are not reset asynchronously. Only the sweep zeroes them.
- Reset asserted mid-sweep: the sweep restarts from address 0 after release.

State machine: IDLE, CLEAR
- IDLE, clear=1 -> CLEAR. Counter is loaded with 0 and busy=1 from the next cycle.
- IDLE, clear=0 -> IDLE. Normal access.
- CLEAR: each cycle writes 0 to RAM[counter] and increments the counter.
- CLEAR, counter=DEPTH-1 -> IDLE. That cycle's zero write completes.
- The sweep therefore takes exactly DEPTH cycles. busy is high for DEPTH cycles.
- clr_done pulses high for 1 cycle, the first cycle back in IDLE.
- clear while in CLEAR is ignored; the sweep does not restart.

Access rules in IDLE
- load=1 with address < DEPTH: RAM[address] <= in at the rising edge.
- Reads, READ_REG=0: out = RAM[address] combinationally. After a write, out shows the new value.
- Reads, READ_REG=1: out <= RAM[address] at each rising edge. This is read-before-write: a same-cycle write to the same address returns the old value, and the new value appears on the next read.

Access rules during CLEAR (busy=1)
- load is ignored; no write takes place.
- out = 0 in both read modes.

Simultaneous events and bounds
- clear and load in the same IDLE cycle: clear wins and the write is dropped.
- Address >= DEPTH (only possible when DEPTH < 2**ADDR_W): writes are ignored and reads return 0.

Widths
- Sweep counter is ADDR_W bits wide.
- Comparison is against DEPTH-1; no wrap occurs because the sweep terminates at DEPTH-1.

Decomposition:
- Package ram_pkg holds:
  - typedef enum logic {ST_IDLE, ST_CLEAR} ram_clr_state_t
  - localparam constants RD_COMB=0 and RD_REG=1
- Sub-module ram_clr_seq holds the FSM, sweep counter, busy and clr_done.
  - Outputs to the top level: wr_en_clr, wr_addr_clr.
  - The top level muxes the sweep write against the user write and holds the storage array and read path.

Test Plan:
- Auto-clear after reset (ADDR_W=4, DEPTH=16, CLR_ON_RESET=1):
  - Pulse rst_n low, release, drive load=1 throughout.
  - Required: busy=1 for exactly 16 cycles, clr_done pulses on cycle 17, all 16 words read 0, no user writes landed.
- Combinational read (READ_REG=0):
  - Write 0xBEEF to address 5, then read address 5 in the next cycle.
  - Required: out=0xBEEF as soon as address=5 is applied after the write edge. Address 6 reads 0.
- Registered read (READ_REG=1):
  - Write 0x1234 to address 3 while address=3 in the same cycle.
  - Required: out=0 (old value) after that edge, and out=0x1234 one cycle later.
- Requested clear and collision:
  - With address 2 holding 0xAAAA, assert clear=1 and load=1 (in=0x5555, address=2) in the same cycle.
  - Required: the write is dropped, busy rises next cycle, and after the sweep address 2 reads 0.
  - A clear pulse mid-sweep must not extend busy beyond 16 cycles.
- Reset mid-sweep:
  - Assert rst_n=0 at sweep count 7 and release.
  - Required: busy=1 again for the full 16 cycles, and clr_done appears only once, at the end.
- Out-of-range (ADDR_W=4, DEPTH=10):
  - Write 0x7777 to address 12, then read address 12.
  - Required: out=0, and addresses 0-9 are unaffected.
